// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM encoding,
// mode-bit positions and the iteration-count helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MODE_HIGH   = 0;
  localparam int MODE_SIGNED = 1;

  function automatic int calc_iter(input int width, input int step_bits);
    return width / step_bits;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One combinational shift-add stage: adds the multiplicand, weighted by each
// of the STEP_BITS low multiplier bits, onto the running accumulator.
module mul_step #(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [2*WIDTH-1:0]   i_mcand,
  input  logic [STEP_BITS-1:0] i_bits,
  output logic [2*WIDTH-1:0]   o_sum
);

  // Partial products for this step's multiplier bits, summed into the accumulator
  always_comb begin
    o_sum = i_acc;
    for (int k = 0; k < STEP_BITS; k++) begin
      if (i_bits[k]) begin
        o_sum = o_sum + (i_mcand << k);
      end else begin
        o_sum = o_sum;
      end
    end
  end

endmodule

// File: rtl/mul_multicycle.sv
// Multi-cycle signed/unsigned multiplier with clk_en/start/done handshake,
// retiring STEP_BITS multiplier bits per BUSY cycle.
module mul_multicycle
  import mul_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic [1:0]       n,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int ITER  = calc_iter(WIDTH, STEP_BITS);
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               r_neg;
  logic               r_high;
  logic               r_done;
  logic               w_accept;
  logic               w_last;

  // Most-negative input maps onto itself, which read unsigned is the correct magnitude
  assign w_mag_a  = (n[MODE_SIGNED] && dataa[WIDTH-1]) ? -dataa : dataa;
  assign w_mag_b  = (n[MODE_SIGNED] && datab[WIDTH-1]) ? -datab : datab;
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == BUSY) && (r_count == LAST_CNT);
  assign w_prod   = r_neg ? -w_sum : w_sum;
  assign result   = r_result;
  assign done     = r_done;

  mul_step #(
    .WIDTH     (WIDTH),
    .STEP_BITS (STEP_BITS)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_bits  (r_mplier[STEP_BITS-1:0]),
    .o_sum   (w_sum)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else if (clk_en) begin
      r_state <= w_next_state;
    end else begin
      r_state <= r_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = BUSY;
        else       w_next_state = IDLE;
      end
      BUSY: begin
        if (r_count == LAST_CNT) w_next_state = DONE;
        else                     w_next_state = BUSY;
      end
      DONE: begin
        if (start) w_next_state = BUSY;
        else       w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iteration, sign fix-up and half select
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_high   <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else if (clk_en) begin
      r_done <= w_last;
      if (w_accept) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
        r_mplier <= w_mag_b;
        r_neg    <= n[MODE_SIGNED] & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
        r_high   <= n[MODE_HIGH];
        r_acc    <= '0;
        r_count  <= '0;
      end else if (r_state == BUSY) begin
        // Shifting the multiplicand each step stands in for << count*STEP_BITS
        r_acc    <= w_sum;
        r_mcand  <= r_mcand << STEP_BITS;
        r_mplier <= r_mplier >> STEP_BITS;
        r_count  <= r_count + 1'b1;
        if (w_last) begin
          r_result <= r_high ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_multicycle.sv
// Scoreboard bench for mul_multicycle: a 32x1 instance checked through a
// queue-driven monitor, plus a 16x4 instance for the re-parametrised case.
module tb_mul_multicycle;

  logic        clk = 1'b0;
  logic        reset_n, clk_en, start;
  logic [31:0] dataa, datab, result;
  logic [1:0]  n;
  logic        done;

  logic        start2;
  logic [15:0] dataa2, datab2, result2;
  logic [1:0]  n2;
  logic        done2;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   e        = 0;

  always #5 clk = ~clk;

  always @(posedge clk) e <= e + 1;

  mul_multicycle #(.WIDTH(32), .STEP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .n(n), .result(result), .done(done)
  );

  mul_multicycle #(.WIDTH(16), .STEP_BITS(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .clk_en(1'b1), .start(start2),
    .dataa(dataa2), .datab(datab2), .n(n2), .result(result2), .done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t x;
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_done: done=1 at edge %0d with no request outstanding", e);
      end else begin
        x = sb.pop_front();
        check(x.name, result, x.res);
        check_int({x.name, "_cycle"}, e, x.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                       input logic [31:0] r, input int extra, input string name);
    exp_t x;
    dataa = a; datab = b; n = m; start = 1'b1;
    x.res = r; x.cyc = e + 1 + 32 + extra; x.name = name;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, required 1", name, k);
    end
  endtask

  initial begin
    int m;
    int k;
    reset_n = 1'b0; clk_en = 1'b1; start = 1'b0;
    dataa = '0; datab = '0; n = 2'b00;
    start2 = 1'b0; dataa2 = '0; datab2 = '0; n2 = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Unsigned basics, chained with starts in the DONE cycle
    issue(32'd332, 32'd22, 2'b00, 32'd7304, 0, "u_332x22");
    wait_done("u_332x22");
    issue(32'd1, 32'd2, 2'b00, 32'd2, 0, "u_1x2_b2b");
    wait_done("u_1x2_b2b");
    issue(32'd2, 32'd23, 2'b00, 32'd46, 0, "u_2x23_b2b");
    wait_done("u_2x23_b2b");
    @(negedge clk);

    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE, 0, "u_max_hi");
    wait_done("u_max_hi"); @(negedge clk);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001, 0, "u_max_lo");
    wait_done("u_max_lo"); @(negedge clk);

    // Signed and mixed-mode cases
    issue(32'hFFFFFFFD, 32'd7, 2'b10, 32'hFFFFFFEB, 0, "s_m3x7_lo");
    wait_done("s_m3x7_lo"); @(negedge clk);
    issue(32'hFFFFFFFD, 32'd7, 2'b11, 32'hFFFFFFFF, 0, "s_m3x7_hi");
    wait_done("s_m3x7_hi"); @(negedge clk);
    issue(32'hFFFFFFFD, 32'd7, 2'b01, 32'h00000006, 0, "u_m3x7_hi");
    wait_done("u_m3x7_hi"); @(negedge clk);
    issue(32'h80000000, 32'h80000000, 2'b11, 32'h40000000, 0, "s_min_hi");
    wait_done("s_min_hi"); @(negedge clk);
    issue(32'h80000000, 32'h80000000, 2'b10, 32'h00000000, 0, "s_min_lo");
    wait_done("s_min_lo"); @(negedge clk);

    // Five stalled edges mid-operation, with starts that must be ignored
    issue(32'd1234, 32'd5678, 2'b00, 32'd7006652, 5, "stall");
    repeat (8) @(negedge clk);
    clk_en = 1'b0;
    @(negedge clk);
    dataa = 32'd99; datab = 32'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clk_en = 1'b1;
    repeat (6) @(negedge clk);
    dataa = 32'd5; datab = 32'd5; n = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("stall"); @(negedge clk);

    // Reset in the middle of an operation aborts it silently
    issue(32'd7, 32'd9, 2'b00, 32'd63, 0, "aborted");
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_result", result, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    void'(sb.pop_back());
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'd2, 32'd3, 2'b00, 32'd6, 0, "after_reset");
    wait_done("after_reset"); @(negedge clk);

    // 16-bit, 4 bits per step: signed -32768 * 3, high half
    m = e;
    dataa2 = 16'h8000; datab2 = 16'h0003; n2 = 2'b11; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    k = 0;
    while (!done2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("w16_result", {16'h0, result2}, 32'h0000FFFE);
    check_int("w16_cycle", e, m + 1 + 4);

    check_int("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
